// File: rtl/cic_pkg.sv
// Shared CIC helper package: sizing and rounding helpers used by the comb chain
// and intended for reuse by other CIC output stages.
package cic_pkg;

  // Smallest number of bits b such that (1 << b) >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Number of accepted samples needed before every comb delay line holds real data.
  function automatic int warmup_len(input int order, input int delay);
    return order * delay;
  endfunction

  // Half-LSB of the output word, expressed at the input width; zero when nothing is dropped.
  function automatic longint unsigned round_const(input int width_in, input int width_out);
    if (width_in > width_out) begin
      return 64'd1 << (width_in - width_out - 1);
    end
    return 64'd0;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x[n-DIFF_DELAY] in modular arithmetic.
// The delay line only advances on valid samples, so sparse input streams work.
module cic_comb_stage #(
  parameter int WIDTH      = 24,
  parameter int DIFF_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] taps [DIFF_DELAY];

  // Delay line plus registered difference; reset and clear both empty the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIFF_DELAY; i++) begin
        taps[i] <= '0;
      end
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DIFF_DELAY; i++) begin
        taps[i] <= '0;
      end
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data - taps[DIFF_DELAY-1];
        taps[0]  <= in_data;
        for (int i = 1; i < DIFF_DELAY; i++) begin
          taps[i] <= taps[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/cic_comb_chain.sv
// Comb section of the variable-rate CIC decimator.
// Cascades CIC_ORDER comb stages, hides warm-up outputs after reset or a rate
// change, and reduces the result to DATA_WIDTH_OUT bits.
// Optional macro CIC_COMB_ROUND_EN: round half-up instead of truncating.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH_INP  = 24,
  parameter int DATA_WIDTH_OUT  = 16,
  parameter int DATA_WIDTH_RATE = 16,
  parameter int CIC_ORDER       = 3,
  parameter int DIFF_DELAY      = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_WIDTH_INP-1:0]  s_axis_in_tdata,
  input  logic                       s_axis_in_tvalid,
  input  logic                       s_axis_rate_tvalid,
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
  output logic [DATA_WIDTH_OUT-1:0]  m_axis_out_tdata,
  output logic                       m_axis_out_tvalid
);

  localparam int WARM_LEN = warmup_len(CIC_ORDER, DIFF_DELAY);
  localparam int CNT_W    = clog2(WARM_LEN + 1);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARM_LEN);

  if (DATA_WIDTH_OUT > DATA_WIDTH_INP) begin : g_bad_width
    $error("cic_comb_chain: DATA_WIDTH_OUT must not exceed DATA_WIDTH_INP");
  end
  if (CIC_ORDER < 1) begin : g_bad_order
    $error("cic_comb_chain: CIC_ORDER must be at least 1");
  end
  if (DIFF_DELAY < 1 || DIFF_DELAY > 2) begin : g_bad_delay
    $error("cic_comb_chain: DIFF_DELAY must be 1 or 2");
  end

  logic [DATA_WIDTH_INP-1:0] stage_data  [CIC_ORDER+1];
  logic                      stage_valid [CIC_ORDER+1];
  logic                      in_accept;
  logic [CNT_W-1:0]          warm_cnt;
  logic                      warm_pipe [CIC_ORDER];
  logic [DATA_WIDTH_INP-1:0] final_rnd;
  logic [DATA_WIDTH_OUT-1:0] out_slice;
  logic [DATA_WIDTH_OUT-1:0] out_held;
  logic                      out_valid;
  logic                      unused_bits;

  // A rate change in the same cycle as a sample wins, so the sample never enters.
  assign in_accept      = s_axis_in_tvalid & ~s_axis_rate_tvalid;
  assign stage_data[0]  = s_axis_in_tdata;
  assign stage_valid[0] = in_accept;

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_stage
    cic_comb_stage #(
      .WIDTH      (DATA_WIDTH_INP),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (s_axis_rate_tvalid),
      .in_data   (stage_data[k]),
      .in_valid  (stage_valid[k]),
      .out_data  (stage_data[k+1]),
      .out_valid (stage_valid[k+1])
    );
  end

  // Count accepted samples until every delay line is filled, then stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (s_axis_rate_tvalid) begin
      warm_cnt <= '0;
    end else if (in_accept && warm_cnt != WARM_MAX) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Tag each sample as warm or not and carry the tag alongside it through the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        warm_pipe[i] <= 1'b0;
      end
    end else if (s_axis_rate_tvalid) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        warm_pipe[i] <= 1'b0;
      end
    end else begin
      warm_pipe[0] <= in_accept && (warm_cnt == WARM_MAX);
      for (int i = 1; i < CIC_ORDER; i++) begin
        warm_pipe[i] <= warm_pipe[i-1];
      end
    end
  end

`ifdef CIC_COMB_ROUND_EN
  localparam logic [DATA_WIDTH_INP-1:0] ROUND_K =
    DATA_WIDTH_INP'(round_const(DATA_WIDTH_INP, DATA_WIDTH_OUT));
  assign final_rnd = stage_data[CIC_ORDER] + ROUND_K;
`else
  assign final_rnd = stage_data[CIC_ORDER];
`endif

  assign out_slice   = final_rnd[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
  assign out_valid   = stage_valid[CIC_ORDER] & warm_pipe[CIC_ORDER-1];
  assign unused_bits = ^{s_axis_rate_tdata, final_rnd};

  // Remember the last delivered word so the output holds between valid pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_held <= '0;
    end else if (s_axis_rate_tvalid) begin
      out_held <= '0;
    end else if (out_valid) begin
      out_held <= out_slice;
    end
  end

  assign m_axis_out_tvalid = out_valid;
  assign m_axis_out_tdata  = out_valid ? out_slice : out_held;

endmodule

// File: doc/cic_comb_chain.md
Name: cic_comb_chain

Overview:
- Comb section of the variable-rate CIC decimator; sits directly downstream of the decimation stage and consumes its sparse, decimated sample stream.
- Implements CIC_ORDER cascaded comb stages with differential delay DIFF_DELAY, in modular two's-complement arithmetic.
- Suppresses warm-up outputs after reset or a rate change, then truncates the result to the output width.

Parameters:
- DATA_WIDTH_INP, 24: width of decimated input samples, already at full integrator bit-growth; all comb arithmetic is done at this width.
- DATA_WIDTH_OUT, 16: output width; must be <= DATA_WIDTH_INP (elaboration-time assertion).
- DATA_WIDTH_RATE, 16: width of the rate word; carried for interface symmetry only, its value is unused.
- CIC_ORDER, 3: number of comb stages N (>= 1).
- DIFF_DELAY, 1: differential delay M per stage, in samples (1 or 2).

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- s_axis_in_tdata  input  DATA_WIDTH_INP  signed decimated sample.
- s_axis_in_tvalid  input  1  sample valid, one-cycle qualifier, no backpressure.
- s_axis_rate_tvalid  input  1  rate-change strobe; synchronous clear of all state.
- s_axis_rate_tdata  input  DATA_WIDTH_RATE  unused.
- m_axis_out_tdata  output  DATA_WIDTH_OUT  signed comb output.
- m_axis_out_tvalid  output  1  output valid.

Behaviour:
- Reset:
  - Asynchronous on reset_n low.
  - All delay-line taps, stage registers, the warm-up counter, m_axis_out_tdata and m_axis_out_tvalid go to 0.
- Stage k, for k = 1..N:
  - Computes y_k = x_k - x_k[n-M], where x_k[n-M] is the M-th previous *valid* sample seen by that stage.
  - The delay line shifts only when that stage's input valid is high.
  - The result is registered, together with a valid bit.
- Latency: exactly CIC_ORDER clocks from an accepted input (s_axis_in_tvalid=1) to its m_axis_out_tvalid pulse.
- Throughput:
  - One sample per clock is sustained, which covers decimation rate 1 (continuous valid).
  - Valids may also be arbitrarily sparse.
- Arithmetic:
  - Subtraction wraps modulo 2^DATA_WIDTH_INP; no saturation, since CIC correctness relies on wrap-around.
  - Output is bits [DATA_WIDTH_INP-1 : DATA_WIDTH_INP-DATA_WIDTH_OUT] of the final stage (truncation toward -inf).
- Warm-up:
  - A counter counts accepted inputs, saturating at N*M.
  - While count < N*M, the output valid that is produced (N clocks later) is forced to 0, and m_axis_out_tdata holds its previous value.
  - Counter width is clog2(N*M+1).
- m_axis_out_tdata updates only on cycles where an output is valid and holds otherwise.
- m_axis_out_tvalid is a single-cycle pulse per valid output.
- Clear (s_axis_rate_tvalid=1):
  - Synchronous; zeroes all delay lines, stage valid bits, the warm-up counter, m_axis_out_tdata and m_axis_out_tvalid.
  - In-flight samples are discarded.
  - If s_axis_in_tvalid is high in the same cycle, clear wins and the sample is dropped.
- Reset asserted mid-pipeline: all in-flight data is lost; after reset the warm-up restarts from 0.

Optional Feature:
- Macro: CIC_COMB_ROUND_EN.
- Defined:
  - Output is rounded half-up: add 1 << (DATA_WIDTH_INP-DATA_WIDTH_OUT-1) to the final stage value, then take the MSB slice.
  - The addition wraps modulo 2^DATA_WIDTH_INP.
  - It is done in the output register stage, so latency is unchanged.
  - When DATA_WIDTH_OUT == DATA_WIDTH_INP, no rounding constant is added.
- Undefined: plain truncation as described under Behaviour.

Decomposition:
- Shared package cic_pkg:
  - clog2 constant function.
  - Warm-up length constant function (order*delay).
  - Rounding-constant function, shared with future CIC output stages.
- One sub-module, cic_comb_stage: parameters WIDTH and DIFF_DELAY; ports clk, reset_n, clr, in_data, in_valid, out_data, out_valid.
- Top level generates CIC_ORDER instances and adds the warm-up counter and output slice/round register.

Test Plan (N=2, M=1, DATA_WIDTH_INP=DATA_WIDTH_OUT=16 unless stated):
- Reset: assert reset_n=0 mid-stream -> both outputs 0 asynchronously; the first 2 post-reset inputs give no m_axis_out_tvalid.
- Step response: inputs 0,0,0,0,7,7,7 at continuous valid -> valid outputs 0,0,7,-7,0, each 2 clocks after its input.
- Sparse valid: same step with valid every 5th clock -> identical output values, one pulse per input, latency 2 clocks.
- Wrap-around: inputs 0,0,-32768,32767 -> stage-1 value for the last sample is -1; the final output sequence matches a modulo-2^16 reference model.
- Clear collision: assert s_axis_rate_tvalid together with s_axis_in_tvalid carrying 100 -> the sample is dropped, the output valid is 0, and the next 2 inputs are suppressed by warm-up.
- Truncation and rounding (DATA_WIDTH_OUT=8): final stage value 0x0180 -> output 0x01 without CIC_COMB_ROUND_EN, 0x02 with it.
